// File: rtl/fu_dispatch_arbiter_pkg.sv
// Shared issue-stage types: functional-unit encoding used on the scheduler request bus.
// Pure declarations, no logic.
package gpu_issue_pkg;

  typedef enum logic [1:0] {
    UNIT_ALU = 2'd0,
    UNIT_SFU = 2'd1,
    UNIT_LSU = 2'd2,
    UNIT_BRU = 2'd3
  } fu_unit_t;

  localparam int NUM_UNITS = 4;

endpackage

// File: rtl/fu_dispatch_arbiter_if.sv
// Scheduler-to-dispatch bundle: issue requests with combinational acks, registered
// per-unit dispatch, plus LSU credit return and status flags.
interface fu_dispatch_arbiter_if #(
  parameter int NS          = 2,
  parameter int W           = 32,
  parameter int LSU_CREDITS = 4
);
  import gpu_issue_pkg::*;

  localparam int WIDX = (W <= 1) ? 1 : $clog2(W);
  localparam int SIDX = (NS <= 1) ? 1 : $clog2(NS);
  localparam int CW   = $clog2(LSU_CREDITS + 1);

  logic [NS-1:0]             req_valid;
  logic [NS*WIDX-1:0]        req_warp_id;
  logic [NS*2-1:0]           req_unit;
  logic [NS-1:0]             req_ack;
  logic [NUM_UNITS-1:0]      disp_valid;
  logic [NUM_UNITS*WIDX-1:0] disp_warp_id;
  logic [NUM_UNITS*SIDX-1:0] disp_src;
  logic                      lsu_credit_return;
  logic [CW-1:0]             lsu_credits;
  logic                      sfu_busy;
  logic                      credit_overflow;

  modport master (
    output req_valid, req_warp_id, req_unit, lsu_credit_return,
    input  req_ack, disp_valid, disp_warp_id, disp_src, lsu_credits, sfu_busy, credit_overflow
  );

  modport slave (
    input  req_valid, req_warp_id, req_unit, lsu_credit_return,
    output req_ack, disp_valid, disp_warp_id, disp_src, lsu_credits, sfu_busy, credit_overflow
  );

endinterface

// File: rtl/fu_dispatch_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping at N.
// Zero latency; en low suppresses every grant.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N <= 1) ? 1 : $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] winner
);

  always_comb begin : pick
    logic          found;
    logic [PW-1:0] idx;
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = idx;
      end
    end
  end

endmodule

// File: rtl/fu_dispatch_arbiter.sv
// Per-unit round-robin issue arbiter for ALU/SFU/LSU/BRU; acks same cycle, dispatch one cycle later.
// Back-pressure only via SFU initiation interval and LSU credits; held requests wait for ack.
module fu_dispatch_arbiter
  import gpu_issue_pkg::*;
#(
  parameter int NS          = 2,
  parameter int W           = 32,
  parameter int SFU_II      = 4,
  parameter int LSU_CREDITS = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  fu_dispatch_arbiter_if.slave bus
);

  localparam int WIDX = (W <= 1) ? 1 : $clog2(W);
  localparam int SIDX = (NS <= 1) ? 1 : $clog2(NS);
  localparam int CW   = $clog2(LSU_CREDITS + 1);
  localparam int SCW  = (SFU_II <= 1) ? 1 : $clog2(SFU_II);

  logic [NUM_UNITS-1:0]      unit_avail;
  logic [NUM_UNITS-1:0]      unit_grant;
  logic [NS-1:0]             cand   [NUM_UNITS];
  logic [NS-1:0]             grant  [NUM_UNITS];
  logic [SIDX-1:0]           winner [NUM_UNITS];
  logic [NS-1:0]             ack;

  logic [SIDX-1:0]           rr_ptr_q [NUM_UNITS];
  logic [SIDX-1:0]           rr_ptr_d [NUM_UNITS];
  logic [SCW-1:0]            sfu_cnt_q, sfu_cnt_d;
  logic [CW-1:0]             credits_q, credits_d;
  logic                      ovf_q, ovf_d;
  logic [NUM_UNITS-1:0]      disp_valid_q, disp_valid_d;
  logic [NUM_UNITS*WIDX-1:0] disp_warp_q, disp_warp_d;
  logic [NUM_UNITS*SIDX-1:0] disp_src_q, disp_src_d;
  logic                      credits_full;

  assign credits_full = (credits_q == CW'(LSU_CREDITS));

  // Availability looks only at registered state, so a same-cycle credit return cannot unblock LSU.
  always_comb begin
    unit_avail           = '1;
    unit_avail[UNIT_SFU] = (sfu_cnt_q == '0);
    unit_avail[UNIT_LSU] = (credits_q != '0);
  end

  always_comb begin
    fu_unit_t s_unit;
    s_unit = UNIT_ALU;
    for (int u = 0; u < NUM_UNITS; u++) begin
      cand[u] = '0;
      for (int s = 0; s < NS; s++) begin
        s_unit     = fu_unit_t'(bus.req_unit[s*2 +: 2]);
        cand[u][s] = bus.req_valid[s] && (s_unit == fu_unit_t'(u));
      end
    end
  end

  for (genvar gu = 0; gu < NUM_UNITS; gu++) begin : g_arb
    rr_arbiter #(.N(NS), .PW(SIDX)) u_rr (
      .req    (cand[gu]),
      .ptr    (rr_ptr_q[gu]),
      .en     (unit_avail[gu] & rst_n),
      .grant  (grant[gu]),
      .winner (winner[gu])
    );
  end

  always_comb begin
    ack        = '0;
    unit_grant = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      ack           = ack | grant[u];
      unit_grant[u] = |grant[u];
    end
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    disp_valid_d = unit_grant;
    disp_warp_d  = disp_warp_q;
    disp_src_d   = disp_src_q;
    sfu_cnt_d    = sfu_cnt_q;
    credits_d    = credits_q;
    ovf_d        = ovf_q;

    for (int u = 0; u < NUM_UNITS; u++) begin
      if (unit_grant[u]) begin
        rr_ptr_d[u] = (winner[u] == SIDX'(NS - 1)) ? '0 : winner[u] + 1'b1;
        disp_warp_d[u*WIDX +: WIDX] = bus.req_warp_id[int'(winner[u])*WIDX +: WIDX];
        disp_src_d[u*SIDX +: SIDX]  = winner[u];
      end
    end

    if (unit_grant[UNIT_SFU]) begin
      sfu_cnt_d = SCW'(SFU_II - 1);
    end else if (sfu_cnt_q != '0) begin
      sfu_cnt_d = sfu_cnt_q - 1'b1;
    end

    case ({unit_grant[UNIT_LSU], bus.lsu_credit_return})
      2'b10: credits_d = credits_q - 1'b1;
      2'b01: begin
        if (credits_full) ovf_d = 1'b1;
        else              credits_d = credits_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int u = 0; u < NUM_UNITS; u++) rr_ptr_q[u] <= '0;
      sfu_cnt_q    <= '0;
      credits_q    <= CW'(LSU_CREDITS);
      ovf_q        <= 1'b0;
      disp_valid_q <= '0;
      disp_warp_q  <= '0;
      disp_src_q   <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      sfu_cnt_q    <= sfu_cnt_d;
      credits_q    <= credits_d;
      ovf_q        <= ovf_d;
      disp_valid_q <= disp_valid_d;
      disp_warp_q  <= disp_warp_d;
      disp_src_q   <= disp_src_d;
    end
  end

  assign bus.req_ack         = ack;
  assign bus.disp_valid      = disp_valid_q;
  assign bus.disp_warp_id    = disp_warp_q;
  assign bus.disp_src        = disp_src_q;
  assign bus.lsu_credits     = credits_q;
  assign bus.sfu_busy        = (sfu_cnt_q != '0);
  assign bus.credit_overflow = ovf_q;

endmodule

// File: tb/tb_fu_dispatch_arbiter.sv
// Bench for fu_dispatch_arbiter: directed literal scenarios, then randomized traffic,
// all cycles also checked against a cycle-count/queue-level model.
module tb_fu_dispatch_arbiter;

  localparam int NS     = 2;
  localparam int W      = 32;
  localparam int WIDX   = 5;
  localparam int SIDX   = 1;
  localparam int SFU_II = 4;
  localparam int LC     = 4;

  logic clk;
  logic rst_n;

  fu_dispatch_arbiter_if #(.NS(NS), .W(W), .LSU_CREDITS(LC)) bus ();

  fu_dispatch_arbiter #(.NS(NS), .W(W), .SFU_II(SFU_II), .LSU_CREDITS(LC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors    = 0;
  int miscompares = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int       m_cycle = 0;
  int       m_sfu_ready = 0;   // first cycle at which SFU may be granted again
  int       m_cred = LC;
  bit       m_ovf = 1'b0;
  int       m_ptr [4];
  int       m_dv  [4];
  int       m_dw  [4];
  int       m_ds  [4];
  logic [NS-1:0] m_ack_last = '0;

  always @(negedge clk) begin : cmp
    int win [4];
    int best_d;
    int d;
    bit avail;
    bit g;
    bit r;
    logic [NS-1:0] eack;
    m_cycle++;
    eack = '0;
    for (int u = 0; u < 4; u++) win[u] = -1;
    if (!rst_n) begin
      for (int u = 0; u < 4; u++) begin
        m_ptr[u] = 0; m_dv[u] = 0; m_dw[u] = 0; m_ds[u] = 0;
      end
      m_cred = LC; m_ovf = 1'b0; m_sfu_ready = m_cycle;
    end else begin
      for (int u = 0; u < 4; u++) begin
        avail = (u == 1) ? (m_cycle >= m_sfu_ready) : (u == 2) ? (m_cred > 0) : 1'b1;
        best_d = NS;
        if (avail) begin
          for (int s = 0; s < NS; s++) begin
            if (bus.req_valid[s] && int'(bus.req_unit[s*2 +: 2]) == u) begin
              d = (s - m_ptr[u] + NS) % NS;
              if (d < best_d) begin best_d = d; win[u] = s; end
            end
          end
        end
        if (win[u] >= 0) eack[win[u]] = 1'b1;
      end
    end

    check("m_ack", int'(bus.req_ack), int'(eack));
    for (int u = 0; u < 4; u++) begin
      check($sformatf("m_disp_valid[%0d]", u), int'(bus.disp_valid[u]), m_dv[u]);
      check($sformatf("m_disp_warp[%0d]", u), int'(bus.disp_warp_id[u*WIDX +: WIDX]), m_dw[u]);
      check($sformatf("m_disp_src[%0d]", u), int'(bus.disp_src[u*SIDX +: SIDX]), m_ds[u]);
    end
    check("m_lsu_credits", int'(bus.lsu_credits), m_cred);
    check("m_sfu_busy", int'(bus.sfu_busy), int'(m_cycle < m_sfu_ready));
    check("m_overflow", int'(bus.credit_overflow), int'(m_ovf));

    if (rst_n) begin
      for (int u = 0; u < 4; u++) begin
        if (win[u] >= 0) begin
          m_ptr[u] = (win[u] + 1) % NS;
          m_dv[u]  = 1;
          m_dw[u]  = int'(bus.req_warp_id[win[u]*WIDX +: WIDX]);
          m_ds[u]  = win[u];
        end else begin
          m_dv[u] = 0;
        end
      end
      if (win[1] >= 0) m_sfu_ready = m_cycle + SFU_II;
      g = (win[2] >= 0);
      r = bus.lsu_credit_return;
      if (g && !r) m_cred--;
      else if (r && !g) begin
        if (m_cred == LC) m_ovf = 1'b1;
        else              m_cred++;
      end
    end
    m_ack_last = eack;
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v0, input int u0, input int w0,
                       input bit v1, input int u1, input int w1, input bit ret);
    bus.req_valid         = {v1, v0};
    bus.req_unit          = {2'(u1), 2'(u0)};
    bus.req_warp_id       = {WIDX'(w1), WIDX'(w0)};
    bus.lsu_credit_return = ret;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] fair_ack [4];
  int         fair_warp [4];
  bit         pv [NS];
  int         pu [NS];
  int         pw [NS];

  initial begin
    fair_ack  = '{2'b01, 2'b10, 2'b01, 2'b10};
    fair_warp = '{3, 9, 3, 9};
    rst_n = 1'b0;
    drive(1, 1, 2, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ack", int'(bus.req_ack), 0);
    check("reset_disp_valid", int'(bus.disp_valid), 0);
    check("reset_credits", int'(bus.lsu_credits), LC);
    check("reset_sfu_busy", int'(bus.sfu_busy), 0);
    check("reset_overflow", int'(bus.credit_overflow), 0);
    @(posedge clk); #1;
    idle();
    rst_n = 1'b1;

    // Fairness on ALU
    for (int k = 0; k < 5; k++) begin
      step();
      if (k < 4) drive(1, 0, 3, 1, 0, 9, 0); else idle();
      @(negedge clk);
      if (k < 4) check("fair_ack", int'(bus.req_ack), int'(fair_ack[k]));
      if (k > 0) begin
        check("fair_disp_valid", int'(bus.disp_valid[0]), 1);
        check("fair_disp_warp", int'(bus.disp_warp_id[0 +: WIDX]), fair_warp[k-1]);
      end
    end

    // Parallel SFU + LSU grants
    step(); drive(1, 1, 5, 1, 2, 7, 0);
    @(negedge clk);
    check("par_ack", int'(bus.req_ack), 3);
    step(); idle();
    @(negedge clk);
    check("par_disp_valid", int'(bus.disp_valid), 4'b0110);
    check("par_sfu_warp", int'(bus.disp_warp_id[1*WIDX +: WIDX]), 5);
    check("par_lsu_warp", int'(bus.disp_warp_id[2*WIDX +: WIDX]), 7);
    check("par_lsu_src", int'(bus.disp_src[2*SIDX +: SIDX]), 1);
    check("par_credits", int'(bus.lsu_credits), 3);
    repeat (4) begin step(); idle(); end

    // SFU initiation interval
    for (int k = 0; k < 9; k++) begin
      step(); drive(1, 1, 1, 0, 0, 0, 0);
      @(negedge clk);
      check("sfu_ii_ack", int'(bus.req_ack), (k % 4 == 0) ? 1 : 0);
      check("sfu_ii_busy", int'(bus.sfu_busy), (k % 4 != 0) ? 1 : 0);
    end
    step(); idle();

    // LSU credit exhaustion and refill
    step(); drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    check("lsu_pre_credits", int'(bus.lsu_credits), 3);
    step(); idle();
    @(negedge clk);
    check("lsu_full_credits", int'(bus.lsu_credits), 4);
    for (int k = 0; k < 6; k++) begin
      step(); drive(0, 0, 0, 1, 2, 2, 0);
      @(negedge clk);
      check("lsu_ack", int'(bus.req_ack), (k < 4) ? 2 : 0);
      check("lsu_credits", int'(bus.lsu_credits), (k < 4) ? 4 - k : 0);
    end
    step(); drive(0, 0, 0, 1, 2, 2, 1);
    @(negedge clk);
    check("lsu_ret_same_cycle_ack", int'(bus.req_ack), 0);
    step(); drive(0, 0, 0, 1, 2, 2, 0);
    @(negedge clk);
    check("lsu_after_ret_credits", int'(bus.lsu_credits), 1);
    check("lsu_after_ret_ack", int'(bus.req_ack), 2);
    step(); idle();
    @(negedge clk);
    check("lsu_drained", int'(bus.lsu_credits), 0);

    // Grant+return together, then overflow
    step(); drive(0, 0, 0, 0, 0, 0, 1);
    step(); drive(0, 0, 0, 0, 0, 0, 1);
    step(); drive(0, 0, 0, 1, 2, 11, 1);
    @(negedge clk);
    check("both_ack", int'(bus.req_ack), 2);
    check("both_pre_credits", int'(bus.lsu_credits), 2);
    step(); idle();
    @(negedge clk);
    check("both_credits", int'(bus.lsu_credits), 2);
    step(); drive(0, 0, 0, 0, 0, 0, 1);
    step(); drive(0, 0, 0, 0, 0, 0, 1);
    step(); idle();
    @(negedge clk);
    check("ovf_pre_credits", int'(bus.lsu_credits), 4);
    check("ovf_pre_flag", int'(bus.credit_overflow), 0);
    step(); drive(0, 0, 0, 0, 0, 0, 1);
    step(); idle();
    @(negedge clk);
    check("ovf_credits", int'(bus.lsu_credits), 4);
    check("ovf_flag", int'(bus.credit_overflow), 1);
    repeat (3) begin step(); idle(); end
    @(negedge clk);
    check("ovf_sticky", int'(bus.credit_overflow), 1);

    // Reset mid-operation with sfu_cnt=2, credits=1
    for (int k = 0; k < 3; k++) begin
      step();
      if (k == 2) drive(1, 1, 6, 1, 2, 4, 0); else drive(0, 0, 0, 1, 2, 4, 0);
      @(negedge clk);
      check("rst_setup_ack", int'(bus.req_ack), (k == 2) ? 3 : 2);
    end
    step(); idle();
    step(); drive(1, 0, 8, 0, 0, 0, 0);
    @(negedge clk);
    check("rst_pre_credits", int'(bus.lsu_credits), 1);
    check("rst_pre_busy", int'(bus.sfu_busy), 1);
    check("rst_pre_ack", int'(bus.req_ack), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_ack", int'(bus.req_ack), 0);
    check("rst_async_dv", int'(bus.disp_valid), 0);
    check("rst_async_warp", int'(bus.disp_warp_id), 0);
    check("rst_async_src", int'(bus.disp_src), 0);
    check("rst_async_credits", int'(bus.lsu_credits), LC);
    check("rst_async_busy", int'(bus.sfu_busy), 0);
    check("rst_async_ovf", int'(bus.credit_overflow), 0);
    @(negedge clk);
    @(posedge clk); #3;
    idle();
    rst_n = 1'b1;
    step(); drive(1, 1, 4, 0, 0, 0, 0);
    @(negedge clk);
    check("post_rst_sfu_ack", int'(bus.req_ack), 1);
    step(); idle();
    @(negedge clk);
    check("post_rst_dv", int'(bus.disp_valid), 4'b0010);
    check("post_rst_warp", int'(bus.disp_warp_id[1*WIDX +: WIDX]), 4);
    check("post_rst_busy", int'(bus.sfu_busy), 1);

    // Randomized traffic; held requests stay stable until acked
    for (int s = 0; s < NS; s++) begin pv[s] = 0; pu[s] = 0; pw[s] = 0; end
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int s = 0; s < NS; s++) begin
        if (pv[s] && !m_ack_last[s]) begin
          if ($urandom_range(99) < 8) pv[s] = 0;
        end else begin
          pv[s] = ($urandom_range(99) < 70);
          pu[s] = $urandom_range(3);
          pw[s] = $urandom_range(W - 1);
        end
        bus.req_valid[s]           = pv[s];
        bus.req_unit[s*2 +: 2]     = 2'(pu[s]);
        bus.req_warp_id[s*WIDX +: WIDX] = WIDX'(pw[s]);
      end
      bus.lsu_credit_return = ($urandom_range(99) < 25);
      if (c == 1500) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk); #3;
        rst_n = 1'b1;
        for (int s = 0; s < NS; s++) pv[s] = 0;
        idle();
      end
    end
    step(); idle();
    @(negedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
